// File: rtl/vco_adc_decim.sv
// Multi-channel VCO-ADC back-end: synchronises quantizer bitstreams, counts rising
// edges over a programmable window and streams the per-channel counts as one frame.
module vco_adc_decim #(
    parameter int NCH         = 4,
    parameter int CNT_W       = 12,
    parameter int DEC_W       = 10,
    parameter int SYNC_STAGES = 2,
    localparam int CH_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_in,
    input  logic [DEC_W-1:0] dec_ratio,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [NCH-1:0]   quantizer_in,
    output logic [CNT_W-1:0] sample_data,
    output logic [CH_W-1:0]  sample_ch,
    output logic             sample_last,
    output logic             sample_valid,
    input  logic             sample_ready,
    output logic             overrun,
    input  logic             overrun_clr
);

    typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

    logic [NCH-1:0]   r_sync [SYNC_STAGES];
    logic [NCH-1:0]   r_prev;
    logic [NCH-1:0]   w_edge;

    logic [DEC_W-1:0] r_wcnt;
    logic [DEC_W-1:0] r_cur;
    logic             r_active;
    logic [DEC_W-1:0] w_r_eff;
    logic [DEC_W-1:0] w_cur;
    logic             w_run;
    logic             w_wend;

    logic [CNT_W-1:0] w_snap [NCH];

    state_t           r_state;
    state_t           w_state_next;
    logic             r_pend;
    logic [NCH-1:0]   r_mask_l;
    logic [CH_W-1:0]  r_idx;
    logic [CH_W-1:0]  w_idx_next;
    logic [CH_W-1:0]  w_lowest;
    logic [CH_W-1:0]  w_higher;
    logic             w_has_higher;
    logic             r_overrun;

    // Synchronisers run regardless of enable so re-enabling never sees stale data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= quantizer_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_edge  = r_sync[SYNC_STAGES-1] & ~r_prev;

    // The first cycle of a window uses the live ratio; r_cur holds it thereafter
    assign w_r_eff = (dec_ratio < DEC_W'(2)) ? DEC_W'(2) : dec_ratio;
    assign w_cur   = r_active ? r_cur : w_r_eff;
    assign w_run   = ~enable_in;
    assign w_wend  = w_run && (r_wcnt == (w_cur - DEC_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wcnt   <= '0;
            r_cur    <= '0;
            r_active <= 1'b0;
        end else if (!w_run || w_wend) begin
            r_wcnt   <= '0;
            r_active <= 1'b0;
        end else begin
            r_wcnt <= r_wcnt + DEC_W'(1);
            if (!r_active) begin
                r_active <= 1'b1;
                r_cur    <= w_r_eff;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_snap;
            logic [CNT_W-1:0] w_cnt_inc;

            assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(w_edge[gi]);
            assign w_snap[gi] = r_snap;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!w_run || w_wend) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_inc;
                end
            end

            // The boundary-cycle edge belongs to the window that is ending
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_snap <= '0;
                end else if (w_wend && (r_state == S_IDLE)) begin
                    r_snap <= w_cnt_inc;
                end
            end
        end
    endgenerate

    // Lowest set channel overall, and lowest set channel above the current one
    always_comb begin
        w_lowest     = '0;
        w_higher     = '0;
        w_has_higher = 1'b0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (r_mask_l[j]) begin
                w_lowest = CH_W'(j);
            end
            if (r_mask_l[j] && (j > int'(r_idx))) begin
                w_higher     = CH_W'(j);
                w_has_higher = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (r_pend && (|r_mask_l)) begin
                    w_state_next = S_SEND;
                    w_idx_next   = w_lowest;
                end
            end
            S_SEND: begin
                if (sample_ready) begin
                    if (w_has_higher) begin
                        w_idx_next = w_higher;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        sample_valid = 1'b0;
        sample_data  = '0;
        sample_ch    = '0;
        sample_last  = 1'b0;
        if (r_state == S_SEND) begin
            sample_valid = 1'b1;
            sample_data  = w_snap[r_idx];
            sample_ch    = r_idx;
            sample_last  = ~w_has_higher;
        end
    end

    // A pending frame is consumed (or dropped for an empty mask) on the next IDLE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend   <= 1'b0;
            r_mask_l <= '0;
            r_idx    <= '0;
        end else begin
            r_idx <= w_idx_next;
            if (w_wend && (r_state == S_IDLE)) begin
                r_pend   <= 1'b1;
                r_mask_l <= ch_mask;
            end else if (r_state == S_IDLE) begin
                r_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_wend && (r_state == S_SEND)) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign overrun = r_overrun;

endmodule

// File: tb/tb_vco_adc_decim.sv
// Directed bench for vco_adc_decim (4 channels, 3-bit counts so saturation is reachable).
module tb_vco_adc_decim;

    localparam int NCH   = 4;
    localparam int CNT_W = 3;
    localparam int DEC_W = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable_in = 1'b1;
    logic [DEC_W-1:0] dec_ratio = '0;
    logic [NCH-1:0]   ch_mask = '0;
    logic [NCH-1:0]   quantizer_in = '0;
    logic [CNT_W-1:0] sample_data;
    logic [1:0]       sample_ch;
    logic             sample_last;
    logic             sample_valid;
    logic             sample_ready = 1'b0;
    logic             overrun;
    logic             overrun_clr = 1'b0;

    logic [NCH-1:0]   tog = '0;
    int               n_checks = 0;
    int               n_errors = 0;

    typedef struct packed {
        logic [CNT_W-1:0] data;
        logic [1:0]       ch;
        logic             last;
    } smp_t;
    smp_t cap_q[$];

    vco_adc_decim #(
        .NCH(NCH), .CNT_W(CNT_W), .DEC_W(DEC_W), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable_in(enable_in), .dec_ratio(dec_ratio),
        .ch_mask(ch_mask), .quantizer_in(quantizer_in), .sample_data(sample_data),
        .sample_ch(sample_ch), .sample_last(sample_last), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // Accepted samples, taken mid-cycle while valid/ready are stable
    always @(negedge clk) begin
        if (rst_n && sample_valid && sample_ready) begin
            cap_q.push_back('{data: sample_data, ch: sample_ch, last: sample_last});
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        quantizer_in = quantizer_in ^ tog;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (sample_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic check_sample(input string tag, input int pos, input int data,
                                input int ch, input int last);
        if (cap_q.size() > pos) begin
            check_val({tag, "_data"}, int'(cap_q[pos].data), data);
            check_val({tag, "_ch"},   int'(cap_q[pos].ch),   ch);
            check_val({tag, "_last"}, int'(cap_q[pos].last), last);
        end else begin
            check_val({tag, "_present"}, cap_q.size(), pos + 1);
        end
    endtask

    initial begin
        bit ok;

        // Reset state
        ticks(3);
        check_val("rst_valid", sample_valid, 0);
        check_val("rst_data", sample_data, 0);
        check_val("rst_overrun", overrun, 0);
        rst_n = 1'b1;

        // All channels toggling, R=8, full mask: four samples of 4 per frame
        dec_ratio = 10'd8; ch_mask = 4'hF; sample_ready = 1'b1; tog = 4'hF;
        ticks(5);
        cap_q.delete();
        enable_in = 1'b0;
        ticks(24);
        enable_in = 1'b1;
        ticks(10);
        check_val("t1_count_ge8", int'(cap_q.size() >= 8), 1);
        for (int i = 0; i < 4; i++) begin
            check_sample($sformatf("t1_s%0d", i), i, 4, i, (i == 3) ? 1 : 0);
        end
        check_val("t1_overrun", overrun, 0);

        // Saturation: only ch2 toggling, R=40 gives 20 edges -> 7
        tog = 4'b0100;
        ticks(5);
        cap_q.delete();
        dec_ratio = 10'd40;
        enable_in = 1'b0;
        ticks(45);
        enable_in = 1'b1;
        ticks(6);
        check_val("t2_count", cap_q.size(), 4);
        check_sample("t2_ch0", 0, 0, 0, 0);
        check_sample("t2_ch2", 2, 7, 2, 0);
        check_sample("t2_ch3", 3, 0, 3, 1);

        // Sparse mask with back-pressure
        tog = 4'hF; dec_ratio = 10'd8; ch_mask = 4'b1010; sample_ready = 1'b0;
        ticks(5);
        cap_q.delete();
        enable_in = 1'b0;
        wait_valid(ok);
        check_val("t3_wait_valid", ok, 1);
        enable_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t3_hold%0d_valid", i), sample_valid, 1);
            check_val($sformatf("t3_hold%0d_ch", i), sample_ch, 1);
            check_val($sformatf("t3_hold%0d_data", i), sample_data, 4);
            check_val($sformatf("t3_hold%0d_last", i), sample_last, 0);
            tick();
        end
        sample_ready = 1'b1;
        ticks(5);
        check_val("t3_count", cap_q.size(), 2);
        check_sample("t3_s0", 0, 4, 1, 0);
        check_sample("t3_s1", 1, 4, 3, 1);

        // Overrun with R=4 and ready held low
        ch_mask = 4'hF; dec_ratio = 10'd4; sample_ready = 1'b0;
        ticks(5);
        cap_q.delete();
        enable_in = 1'b0;
        ticks(10);
        check_val("t4_overrun_set", overrun, 1);
        check_val("t4_valid", sample_valid, 1);
        check_val("t4_ch", sample_ch, 0);
        check_val("t4_data_kept", sample_data, 2);
        enable_in = 1'b1;
        sample_ready = 1'b1;
        ticks(6);
        check_val("t4_count", cap_q.size(), 4);
        check_sample("t4_s3", 3, 2, 3, 1);
        check_val("t4_overrun_sticky", overrun, 1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        check_val("t4_overrun_clr", overrun, 0);

        // Single edge landing on the boundary cycle of the first window
        tog = 4'h0; quantizer_in = 4'h0; dec_ratio = 10'd8;
        ticks(6);
        cap_q.delete();
        enable_in = 1'b0;
        ticks(5);
        quantizer_in = 4'b0001;
        ticks(20);
        enable_in = 1'b1;
        ticks(8);
        check_val("t5_count_ge8", int'(cap_q.size() >= 8), 1);
        check_sample("t5_w0_ch0", 0, 1, 0, 0);
        check_sample("t5_w0_ch1", 1, 0, 1, 0);
        check_sample("t5_w1_ch0", 4, 0, 0, 0);

        // Asynchronous reset in the middle of a frame, with overrun set
        tog = 4'hF; dec_ratio = 10'd4; sample_ready = 1'b0;
        ticks(5);
        enable_in = 1'b0;
        ticks(10);
        check_val("t6_pre_valid", sample_valid, 1);
        check_val("t6_pre_overrun", overrun, 1);
        rst_n = 1'b0;
        #2;
        check_val("t6_rst_valid", sample_valid, 0);
        check_val("t6_rst_data", sample_data, 0);
        check_val("t6_rst_ch", sample_ch, 0);
        check_val("t6_rst_overrun", overrun, 0);
        enable_in = 1'b1;
        tick();
        rst_n = 1'b1;

        // dec_ratio of 0 and 1 both behave as a 2-cycle window: one edge per window
        ch_mask = 4'b0001; sample_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            dec_ratio = DEC_W'(r);
            ticks(5);
            cap_q.delete();
            enable_in = 1'b0;
            ticks(12);
            enable_in = 1'b1;
            ticks(6);
            check_sample($sformatf("t7_r%0d", r), 0, 1, 0, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vco_adc_decim.md
Name: vco_adc_decim

Overview:
Parametrised multi-channel digital back-end for the VCO-ADC quantizer macros. It takes NCH single-bit quantizer streams and synchronises each one. It counts rising edges (VCO phase transitions) per channel over a programmable decimation window of R clk cycles. At each window end it serialises the per-channel counts onto one valid/ready sample stream toward the system bus. It replaces direct sampling of a single quantizer_out with a channel-scalable, saturating, back-pressure-aware frame output.

Parameters:
NCH, 4, number of quantizer channels (1..16)
CNT_W, 12, width of each output count; counts saturate at 2^CNT_W-1
DEC_W, 10, width of dec_ratio
SYNC_STAGES, 2, synchroniser flops per quantizer input (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
enable_in  input  1  active-low enable, same polarity as the quantizer macro; 0 = converting
dec_ratio  input  DEC_W  window length R in clk cycles
ch_mask  input  NCH  1 = channel included in output frames
quantizer_in  input  NCH  asynchronous quantizer bitstreams, bit i = channel i
sample_data  output  CNT_W  edge count of current channel
sample_ch  output  max(1,$clog2(NCH))  channel index of sample_data
sample_last  output  1  marks the last sample of a frame
sample_valid  output  1  sample present
sample_ready  input  1  consumer accepts when valid&ready
overrun  output  1  sticky: a window ended while the previous frame was still being sent
overrun_clr  input  1  synchronous clear of overrun

Behaviour:
- Reset (rst_n=0, async): synchronisers, edge registers, counters, window counter, snapshots, FSM = IDLE. All outputs 0.
- Sync: SYNC_STAGES flops per bit, then one previous-value flop. edge[i] = s[i] & ~prev[i]. Input rising edge is reflected in edge[i] SYNC_STAGES+1 cycles later.
- Window: R_eff = max(dec_ratio, 2), latched into r_cur when a window starts. The first window starts on the first cycle with enable_in=0 after reset/disable. wcnt runs 0..r_cur-1.
- Per channel, cnt[i] += edge[i] every cycle of the window, saturating at 2^CNT_W-1 (never wraps).
- Last window cycle (wcnt==r_cur-1): snap[i] = sat(cnt[i] + edge[i]). cnt[i] restarts at 0 and wcnt restarts at 0 with a fresh dec_ratio latch. Each window therefore covers exactly r_cur edge-sample cycles; no edge is lost or double-counted across the boundary.
- dec_ratio changes mid-window take effect at the next window only.
- Snapshot transfer: at window end, if FSM is IDLE, snap is loaded and the frame is pending.
- If FSM is SEND at window end, the new snapshot is discarded, the old frame continues, and overrun<=1. overrun_clr clears the flag; a set in the same cycle as a clear wins.
- FSM IDLE: if a frame is pending and ch_mask latched at window end (mask_l) != 0, go to SEND with idx = lowest set bit of mask_l. If mask_l==0, drop the frame and stay IDLE.
- FSM SEND: sample_valid=1, sample_data=snap[idx], sample_ch=idx, sample_last=1 iff no higher set bit in mask_l.
  - On valid&ready, advance to the next set bit, or go to IDLE after the last sample. Next sample is offered the following cycle; 1 sample/cycle max throughput.
  - Outputs are held stable while valid&~ready.
  - A window end coinciding with acceptance of the last sample counts as SEND, so it is an overrun.
- Disable (enable_in 1): wcnt and cnt are cleared and held at 0, and no window end occurs. Synchronisers keep running. A frame already in SEND completes normally.
- Re-enable starts a fresh full window.
- sample_valid never deasserts without a handshake, except on reset.

Test Plan:
- NCH=4, R=8, all channels toggling each clk (edge every 2 cycles), mask=4'hF, ready=1 -> 4 samples per window, each data=4, ch=0..3, last on ch3, no overrun.
- Channel 2 toggling every cycle, CNT_W=3, R=40 -> ch2 data=7 (saturated), others 0.
- mask=4'b1010, ready held 0 for 3 cycles -> ch1 presented and held stable; after ready, ch1 then ch3 with last=1; ch0/ch2 never output.
- R=4, ready=0 for 10 cycles -> overrun=1 after the second window end; first frame data unchanged; pulse overrun_clr -> overrun=0.
- Single input edge placed so edge[] fires on the boundary cycle wcnt=R-1 -> counted in the ending window (data=1); next window data=0.
- Assert rst_n=0 during SEND -> valid, data, ch, overrun all 0 immediately. Set dec_ratio=0 and 1 -> window length 2 cycles.
